// File: rtl/cache_pkg.sv
// Shared types and geometry for the cache line fill sequencer.
// Two-way caches, 16-byte blocks of eight 16-bit words.
package cache_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFFSET_BITS     = 4;
  localparam int INDEX_BITS      = 6;
  localparam int TAG_BITS        = 6;
  localparam int ADDR_BITS       = 16;
  localparam int WORD_BITS       = 16;
  localparam int CNT_BITS        = $clog2(WORDS_PER_BLOCK);

  localparam logic [CNT_BITS-1:0] LAST_WORD =
    CNT_BITS'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    TAG  = 2'b10
  } state_t;

  function automatic logic [ADDR_BITS-1:0] block_base(
    input logic [ADDR_BITS-1:0] a
  );
    return {a[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Miss request, main-memory read port and array write port
// of the fill sequencer, bundled as one interface.
interface cache_fill_fsm_if
  import cache_pkg::*;
;

  logic                  miss_detected;
  logic [ADDR_BITS-1:0]  miss_address;
  logic                  victim_way;
  logic                  fsm_busy;
  logic                  memory_read;
  logic [ADDR_BITS-1:0]  memory_address;
  logic                  memory_data_valid;
  logic [WORD_BITS-1:0]  memory_data;
  logic                  write_data_array;
  logic                  write_tag_array;
  logic                  fill_way;
  logic [CNT_BITS-1:0]   fill_word;
  logic [WORD_BITS-1:0]  fill_data;
  logic [TAG_BITS-1:0]   fill_tag;
  logic [INDEX_BITS-1:0] fill_index;

  modport master (
    input  miss_detected, miss_address, victim_way,
    input  memory_data_valid, memory_data,
    output fsm_busy, memory_read, memory_address,
    output write_data_array, write_tag_array,
    output fill_way, fill_word, fill_data,
    output fill_tag, fill_index
  );

  modport slave (
    output miss_detected, miss_address, victim_way,
    output memory_data_valid, memory_data,
    input  fsm_busy, memory_read, memory_address,
    input  write_data_array, write_tag_array,
    input  fill_way, fill_word, fill_data,
    input  fill_tag, fill_index
  );

endinterface

// File: rtl/fill_counter.sv
// Word counter for one side of a fill; saturates at the last
// word and raises done instead of wrapping.
module fill_counter
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  output logic [CNT_BITS-1:0] cnt,
  output logic                done
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (en && !done) begin
      if (cnt == LAST_WORD) done <= 1'b1;
      else cnt <= cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: issues eight word reads, streams the
// returned words into the data array, then writes the tag.
module cache_fill_fsm
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  cache_fill_fsm_if.master bus
);

  state_t                state;
  logic [ADDR_BITS-1:0]  base;
  logic                  way;
  logic [TAG_BITS-1:0]   tag;
  logic [INDEX_BITS-1:0] index;

  logic                  accept;
  logic                  issue_en;
  logic                  recv_en;
  logic                  recv_last;
  logic                  issue_done;
  logic                  recv_done;
  logic [CNT_BITS-1:0]   issue_cnt;
  logic [CNT_BITS-1:0]   recv_cnt;

  assign accept    = (state == IDLE) && bus.miss_detected;
  assign issue_en  = (state == FILL) && !issue_done;
  assign recv_en   = (state == FILL) && bus.memory_data_valid
                     && !recv_done;
  assign recv_last = recv_en && (recv_cnt == LAST_WORD);

  fill_counter u_issue (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (issue_en),
    .cnt  (issue_cnt),
    .done (issue_done)
  );

  fill_counter u_recv (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (recv_en),
    .cnt  (recv_cnt),
    .done (recv_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      base  <= '0;
      way   <= 1'b0;
      tag   <= '0;
      index <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.miss_detected) begin
          state <= FILL;
          base  <= block_base(bus.miss_address);
          way   <= bus.victim_way;
          tag   <= bus.miss_address[ADDR_BITS-1 -: TAG_BITS];
          index <= bus.miss_address[OFFSET_BITS +: INDEX_BITS];
        end
        FILL: if (recv_last) state <= TAG;
        TAG:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Word offset never carries past the block boundary.
  assign bus.memory_address = issue_en
    ? base + ADDR_BITS'({issue_cnt, 1'b0})
    : '0;

  assign bus.fsm_busy         = (state != IDLE);
  assign bus.memory_read      = issue_en;
  assign bus.write_data_array = recv_en;
  assign bus.write_tag_array  = (state == TAG);
  assign bus.fill_way         = way;
  assign bus.fill_word        = recv_cnt;
  assign bus.fill_data        = bus.memory_data;
  assign bus.fill_tag         = tag;
  assign bus.fill_index       = index;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: latency-L memory responder and a
// cycle-schedule reference for each fill.
module tb_cache_fill_fsm;
  import cache_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;
  int gcyc   = 0;
  int lat    = 4;
  int writes = 0;
  int tags   = 0;
  int due_q[$];
  logic [15:0] mdata;

  cache_fill_fsm_if bus();

  cache_fill_fsm dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs at negedge, memory answers reads
  // issued lat cycles earlier, then observe at negedge+1.
  task automatic drive(input logic miss, input logic spur);
    @(negedge clk);
    gcyc++;
    bus.miss_detected     = miss;
    bus.miss_address      = 16'($urandom);
    bus.victim_way        = 1'($urandom);
    mdata                 = 16'($urandom);
    bus.memory_data       = mdata;
    bus.memory_data_valid = spur;
    if (due_q.size() > 0 && due_q[0] <= gcyc) begin
      void'(due_q.pop_front());
      bus.memory_data_valid = 1'b1;
    end
    #1;
    if (bus.memory_read) due_q.push_back(gcyc + lat);
    if (bus.write_data_array) writes++;
    if (bus.write_tag_array) tags++;
  endtask

  task automatic check_reset();
    check("rst_busy",  32'(bus.fsm_busy), 0);
    check("rst_read",  32'(bus.memory_read), 0);
    check("rst_addr",  32'(bus.memory_address), 0);
    check("rst_wr",    32'(bus.write_data_array), 0);
    check("rst_tagwr", 32'(bus.write_tag_array), 0);
    check("rst_way",   32'(bus.fill_way), 0);
    check("rst_word",  32'(bus.fill_word), 0);
    check("rst_tag",   32'(bus.fill_tag), 0);
    check("rst_index", 32'(bus.fill_index), 0);
  endtask

  task automatic idle_cycle(input logic spur);
    drive(1'b0, spur);
    check("idle_busy",  32'(bus.fsm_busy), 0);
    check("idle_read",  32'(bus.memory_read), 0);
    check("idle_wr",    32'(bus.write_data_array), 0);
    check("idle_tagwr", 32'(bus.write_tag_array), 0);
  endtask

  // Expected schedule relative to the accept cycle 0:
  // reads 1..8, writes l+1..l+8, tag l+9, busy 1..l+9.
  task automatic run_fill(input logic [15:0] addr,
                          input logic way, input int l,
                          input logic spur, input logic hold);
    logic [15:0] base;
    logic miss;
    base   = addr & 16'hFFF0;
    lat    = l;
    writes = 0;
    tags   = 0;
    drive(1'b1, spur);
    bus.miss_address = addr;
    bus.victim_way   = way;
    check("accept_busy", 32'(bus.fsm_busy), 0);
    check("accept_wr", 32'(bus.write_data_array), 0);
    for (int c = 1; c <= l + 9; c++) begin
      miss = hold ? 1'b1 : (spur ? 1'($urandom) : 1'b0);
      drive(miss, spur && (c == l + 9));
      check("busy", 32'(bus.fsm_busy), 1);
      check("read", 32'(bus.memory_read), 32'(c <= 8));
      if (c <= 8)
        check("addr", 32'(bus.memory_address),
              32'(base + 16'(2 * (c - 1))));
      check("wr", 32'(bus.write_data_array),
            32'(c > l && c <= l + 8));
      if (c > l && c <= l + 8) begin
        check("word", 32'(bus.fill_word), c - l - 1);
        check("data", 32'(bus.fill_data), 32'(mdata));
        check("wr_way", 32'(bus.fill_way), 32'(way));
      end
      check("tag_wr", 32'(bus.write_tag_array), 32'(c == l + 9));
      if (c == l + 9) begin
        check("fill_tag", 32'(bus.fill_tag), 32'(addr >> 10));
        check("fill_index", 32'(bus.fill_index),
              32'((addr >> 4) & 16'h3F));
        check("fill_way", 32'(bus.fill_way), 32'(way));
      end
    end
    check("n_writes", writes, 8);
    check("n_tags", tags, 1);
  endtask

  task automatic reset_mid_fill(input logic [15:0] addr, input int l);
    lat    = l;
    writes = 0;
    tags   = 0;
    drive(1'b1, 1'b0);
    bus.miss_address = addr;
    bus.victim_way   = 1'b1;
    for (int c = 1; c <= l + 3; c++) drive(1'b0, 1'b0);
    check("pre_rst_writes", writes, 3);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset();
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    rst_n  = 1'b1;
    writes = 0;
    for (int i = 0; i < 40 && due_q.size() > 0; i++) idle_cycle(1'b0);
    check("rst_drained", due_q.size(), 0);
    check("rst_no_wr", writes, 0);
    check("rst_no_tag", tags, 0);
  endtask

  initial begin
    bus.miss_detected     = 1'b0;
    bus.miss_address      = '0;
    bus.victim_way        = 1'b0;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = '0;
    #2;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;

    run_fill(16'h1A36, 1'b1, 4, 1'b0, 1'b0);
    idle_cycle(1'b0);

    run_fill(16'($urandom), 1'($urandom), 4, 1'b1, 1'b0);
    idle_cycle(1'b1);

    run_fill(16'($urandom), 1'($urandom), 1, 1'b0, 1'b0);
    idle_cycle(1'b0);

    reset_mid_fill(16'($urandom), 4);
    run_fill(16'($urandom), 1'($urandom), 4, 1'b0, 1'b0);
    idle_cycle(1'b0);

    run_fill(16'($urandom), 1'($urandom), 4, 1'b0, 1'b1);
    run_fill(16'($urandom), 1'($urandom), 2, 1'b0, 1'b1);
    run_fill(16'($urandom), 1'($urandom), 3, 1'b0, 1'b0);
    idle_cycle(1'b0);

    for (int i = 0; i < 6; i++) begin
      run_fill(16'($urandom), 1'($urandom),
               int'($urandom_range(1, 6)),
               1'($urandom_range(0, 1)), 1'b0);
      idle_cycle(1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
